// File: rtl/sub_pkg.sv
// Shared types and helpers for the serial subtractor: FSM state encoding,
// default chunk size and the sizing functions used to derive chunk counts.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    localparam int SUB_CHUNK_DEFAULT = 4;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Counter width that stays legal when only one chunk exists.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sub_chunk.sv
// Combinational WIDTH-bit subtractor slice: o_Diff = i_A - i_B - i_Bin.
// Built as A + ~B + ~Bin so the carry chain maps straight onto an adder.
module sub_chunk #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_Bin,
    output logic [WIDTH-1:0] o_Diff,
    output logic             o_Bout
);

    logic [WIDTH:0] sum;

    assign sum    = {1'b0, i_A} + {1'b0, ~i_B} + {{WIDTH{1'b0}}, ~i_Bin};
    assign o_Diff = sum[WIDTH-1:0];
    assign o_Bout = ~sum[WIDTH];

endmodule

// File: rtl/serial_subtractor_nbits.sv
// Multi-cycle A - B - Bin, CHUNK bits per cycle; result valid ceil(WIDTH/CHUNK) cycles after accept.
// Valid/ready both sides; result held until consumed. SUB_SIGNED_OVF_EN enables signed overflow flag.
module serial_subtractor_nbits
    import sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = SUB_CHUNK_DEFAULT
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_Bin,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic [WIDTH-1:0] o_Diff,
    output logic             o_Bout,
    output logic             o_Ovf
);

    localparam int NUM_CHUNK = ceil_div(WIDTH, CHUNK);
    localparam int PADW      = NUM_CHUNK * CHUNK;
    localparam int CNT_W     = cnt_width(NUM_CHUNK);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNK - 1);

    sub_state_e       state_q, state_d;
    logic [PADW-1:0]  a_q, a_d;
    logic [PADW-1:0]  b_q, b_d;
    logic [PADW-1:0]  diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             bout_q, bout_d;

    logic [CHUNK-1:0] chunk_diff;
    logic             chunk_bout;

`ifdef SUB_SIGNED_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
`endif

    // Operands are zero-padded to a whole number of chunks; the padding
    // passes the carry through unchanged, so the final carry is the true one.
    sub_chunk #(
        .WIDTH (CHUNK)
    ) u_chunk (
        .i_A    (a_q[CHUNK-1:0]),
        .i_B    (b_q[CHUNK-1:0]),
        .i_Bin  (~carry_q),
        .o_Diff (chunk_diff),
        .o_Bout (chunk_bout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        bout_d  = bout_q;
`ifdef SUB_SIGNED_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_Valid) begin
                    a_d     = PADW'(i_A);
                    b_d     = PADW'(i_B);
                    carry_d = ~i_Bin;
                    cnt_d   = '0;
                    diff_d  = '0;
                    bout_d  = 1'b0;
`ifdef SUB_SIGNED_OVF_EN
                    a_msb_d = i_A[WIDTH-1];
                    b_msb_d = i_B[WIDTH-1];
                    ovf_d   = 1'b0;
`endif
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Operands shift down, result chunks shift in from the top;
                // after NUM_CHUNK steps chunk 0 sits at bit 0.
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                diff_d  = (diff_q >> CHUNK) | (PADW'(chunk_diff) << (PADW - CHUNK));
                carry_d = ~chunk_bout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    bout_d  = chunk_bout;
`ifdef SUB_SIGNED_OVF_EN
                    ovf_d   = (a_msb_q != b_msb_q) && (diff_d[WIDTH-1] != a_msb_q);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_Ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            bout_q  <= bout_d;
`ifdef SUB_SIGNED_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign o_Ready = (state_q == IDLE);
    assign o_Valid = (state_q == DONE);
    assign o_Diff  = diff_q[WIDTH-1:0];
    assign o_Bout  = bout_q;
`ifdef SUB_SIGNED_OVF_EN
    assign o_Ovf   = ovf_q;
`else
    assign o_Ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor_nbits.sv
// Bench for serial_subtractor_nbits: 16/4 and 10/4 instances, directed table,
// hold/reset sequences and randomized operations against an arithmetic model.
module tb_serial_subtractor_nbits;

`ifdef SUB_SIGNED_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        v16 = 0, ri16 = 0, bin16 = 0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        r16, vo16, bo16, ov16;
    logic [15:0] d16;

    logic        v10 = 0, ri10 = 0, bin10 = 0;
    logic [9:0]  a10 = '0, b10 = '0;
    logic        r10, vo10, bo10, ov10;
    logic [9:0]  d10;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_subtractor_nbits #(.WIDTH(16), .CHUNK(4)) u16 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(v16), .o_Ready(r16),
        .i_A(a16), .i_B(b16), .i_Bin(bin16), .o_Valid(vo16), .i_Ready(ri16),
        .o_Diff(d16), .o_Bout(bo16), .o_Ovf(ov16)
    );

    serial_subtractor_nbits #(.WIDTH(10), .CHUNK(4)) u10 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(v10), .o_Ready(r10),
        .i_A(a10), .i_B(b10), .i_Bin(bin10), .o_Valid(vo10), .i_Ready(ri10),
        .o_Diff(d10), .o_Bout(bo10), .o_Ovf(ov10)
    );

    typedef struct {
        bit          s10;
        logic [15:0] a;
        logic [15:0] b;
        bit          bin;
        logic [15:0] diff;
        bit          bout;
        bit          ovf;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input int w, input logic [15:0] a, input logic [15:0] b, input bit bin,
                         output logic [15:0] d, output bit bo, output bit ov);
        longint full;
        longint mask;
        mask = (longint'(1) << w) - 1;
        full = longint'(a) - longint'(b) - longint'(bin);
        d    = 16'(full & mask);
        bo   = (full < 0);
        ov   = OVF_ON && (a[w-1] != b[w-1]) && (d[w-1] != a[w-1]);
    endtask

    task automatic do_op(input bit s10, input logic [15:0] a, input logic [15:0] b, input bit bin,
                         output logic [15:0] d, output bit bo, output bit ov, output int lat);
        @(negedge clk);
        chk("ready_before_accept", s10 ? r10 : r16, 1);
        if (s10) begin v10 = 1; a10 = a[9:0]; b10 = b[9:0]; bin10 = bin; end
        else     begin v16 = 1; a16 = a;      b16 = b;      bin16 = bin; end
        @(posedge clk); #1;
        lat = 0;
        while (!(s10 ? vo10 : vo16) && lat < 40) begin
            // Junk on the inputs while busy must have no effect.
            if (s10) begin v10 = 1'($urandom); a10 = 10'($urandom); b10 = 10'($urandom); ri10 = 1'($urandom); end
            else     begin v16 = 1'($urandom); a16 = 16'($urandom); b16 = 16'($urandom); ri16 = 1'($urandom); end
            @(posedge clk); #1;
            lat++;
        end
        v10 = 0; ri10 = 0; v16 = 0; ri16 = 0;
        if (s10) begin d = {6'd0, d10}; bo = bo10; ov = ov10; end
        else     begin d = d16;         bo = bo16; ov = ov16; end
    endtask

    task automatic consume(input bit s10);
        @(negedge clk);
        if (s10) ri10 = 1; else ri16 = 1;
        @(posedge clk); #1;
        ri10 = 0; ri16 = 0;
        chk("valid_after_consume", s10 ? vo10 : vo16, 0);
        chk("ready_after_consume", s10 ? r10 : r16, 1);
    endtask

    initial begin
        vec_t        vecs[8];
        logic [15:0] d, d0, ed;
        bit          bo, ov, bo0, ov0, ebo, eov;
        int          lat;

        vecs[0] = '{0, 16'h1234, 16'h0234, 0, 16'h1000, 0, 0, 4};
        vecs[1] = '{0, 16'h0000, 16'h0001, 0, 16'hFFFF, 1, 0, 4};
        vecs[2] = '{0, 16'h8000, 16'h0001, 0, 16'h7FFF, 0, OVF_ON, 4};
        vecs[3] = '{1, 16'h0005, 16'h0005, 1, 16'h03FF, 1, 0, 3};
        vecs[4] = '{0, 16'hFFFF, 16'hFFFF, 1, 16'hFFFF, 1, 0, 4};
        vecs[5] = '{0, 16'h7FFF, 16'hFFFF, 0, 16'h8000, 1, OVF_ON, 4};
        vecs[6] = '{1, 16'h03FF, 16'h0001, 0, 16'h03FE, 0, 0, 3};
        vecs[7] = '{1, 16'h0200, 16'h0001, 0, 16'h01FF, 0, OVF_ON, 3};

        #2 rst_n = 0;
        #1;
        chk("rst_ready16", r16, 1);  chk("rst_valid16", vo16, 0);
        chk("rst_diff16", d16, 0);   chk("rst_bout16", bo16, 0);  chk("rst_ovf16", ov16, 0);
        chk("rst_ready10", r10, 1);  chk("rst_valid10", vo10, 0); chk("rst_diff10", d10, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].s10, vecs[i].a, vecs[i].b, vecs[i].bin, d, bo, ov, lat);
            chk($sformatf("vec%0d_diff", i), d, vecs[i].diff);
            chk($sformatf("vec%0d_bout", i), bo, vecs[i].bout);
            chk($sformatf("vec%0d_ovf", i), ov, vecs[i].ovf);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            consume(vecs[i].s10);
        end

        // Result held while consumer stalls; no accept on the consuming edge.
        do_op(0, 16'h1234, 16'h0234, 0, d0, bo0, ov0, lat);
        chk("hold_first_diff", d0, 16'h1000);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("hold_diff", d16, d0);
            chk("hold_bout", bo16, bo0);
            chk("hold_ovf", ov16, ov0);
            chk("hold_valid", vo16, 1);
            chk("hold_ready", r16, 0);
        end
        @(negedge clk);
        ri16 = 1; v16 = 1; a16 = 16'hFFFF; b16 = 16'h0000;
        @(posedge clk); #1;
        ri16 = 0; v16 = 0;
        chk("consume_valid", vo16, 0);
        chk("consume_ready", r16, 1);
        @(posedge clk); #1;
        chk("no_accept_on_consume", r16, 1);

        // Reset in the second busy cycle discards the operation.
        @(negedge clk);
        v16 = 1; a16 = 16'h00FF; b16 = 16'h0001; bin16 = 0;
        @(posedge clk); #1;
        v16 = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("midrst_ready", r16, 1);
        chk("midrst_valid", vo16, 0);
        chk("midrst_diff", d16, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_result", vo16, 0);
        do_op(0, 16'h00FF, 16'h0001, 1, d, bo, ov, lat);
        chk("postrst_diff", d, 16'h00FD);
        chk("postrst_bout", bo, 0);
        chk("postrst_lat", lat, 4);
        consume(0);

        for (int i = 0; i < 160; i++) begin
            bit          s;
            int          w;
            logic [15:0] a, b;
            bit          bin;
            s   = i[0];
            w   = s ? 10 : 16;
            a   = 16'($urandom);
            b   = 16'($urandom);
            if (i % 8 == 2) a = '0;
            if (i % 8 == 5) b = '1;
            if (s) begin a[15:10] = '0; b[15:10] = '0; end
            bin = 1'($urandom);
            model(w, a, b, bin, ed, ebo, eov);
            do_op(s, a, b, bin, d, bo, ov, lat);
            chk($sformatf("rnd%0d_diff", i), d, ed);
            chk($sformatf("rnd%0d_bout", i), bo, ebo);
            chk($sformatf("rnd%0d_ovf", i), ov, eov);
            chk($sformatf("rnd%0d_lat", i), lat, (w + 3) / 4);
            consume(s);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_nbits.md
SERIAL_SUBTRACTOR_NBITS -- requirements
Module: serial_subtractor_nbits

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, operand/result width in bits (WIDTH >= 1).
REQ-002 SHALL provide parameter CHUNK, default 4, bits subtracted per clock cycle (1 <= CHUNK <= WIDTH).
REQ-003 SHALL have exactly one clock and an asynchronous, active-low reset, with the ports listed below.
REQ-004 SHALL have port i_Clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port i_Rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port i_Valid, input, 1 bit: operands offered.
REQ-007 SHALL have port o_Ready, output, 1 bit: block can accept operands.
REQ-008 SHALL have port i_A, input, WIDTH bits: minuend.
REQ-009 SHALL have port i_B, input, WIDTH bits: subtrahend.
REQ-010 SHALL have port i_Bin, input, 1 bit: borrow-in.
REQ-011 SHALL have port o_Valid, output, 1 bit: result available.
REQ-012 SHALL have port i_Ready, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have port o_Diff, output, WIDTH bits: A - B - Bin modulo 2^WIDTH.
REQ-014 SHALL have port o_Bout, output, 1 bit: unsigned borrow-out (1 iff A < B + Bin).
REQ-015 SHALL have port o_Ovf, output, 1 bit: signed two's-complement overflow.

Function
REQ-016 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-017 SHALL drive o_Ready = 1 only in IDLE.
REQ-018 SHALL drive o_Valid = 1 only in DONE.
REQ-019 On a rising edge with IDLE and i_Valid = 1, SHALL register i_A, i_B and ~i_Bin as the internal carry, clear the chunk counter, and move to BUSY.
REQ-020 In BUSY, on each edge, SHALL compute chunk k as A_k + ~B_k + carry, store the result into the o_Diff slice k, and update the carry.
REQ-021 SHALL take NUM_CHUNK = ceil(WIDTH/CHUNK) as the number of chunks; the last chunk is WIDTH mod CHUNK bits wide when that value is nonzero.
REQ-022 SHALL move from BUSY to DONE on the edge that processes the final chunk, so that o_Valid rises exactly NUM_CHUNK cycles after the accepting edge.
REQ-023 SHALL set o_Bout to the inverse of the final carry.
REQ-024 SHALL set o_Ovf to (A[MSB] != B[MSB]) && (Diff[MSB] != A[MSB]).
REQ-025 In DONE, SHALL hold o_Diff, o_Bout and o_Ovf stable until i_Ready = 1, then return to IDLE on that edge.
REQ-026 SHALL not accept new operands in the cycle where the result is consumed; o_Ready reasserts on the next cycle.
REQ-027 SHALL ignore i_Valid and operand changes while in BUSY or DONE.
REQ-028 SHALL ignore i_Ready outside DONE.
REQ-029 SHALL give a result in which all arithmetic wraps modulo 2^WIDTH.

Reset
REQ-030 On i_Rst_n = 0, SHALL immediately, without waiting for a clock edge, enter IDLE.
REQ-031 During reset, SHALL drive o_Ready = 1, o_Valid = 0, o_Diff = 0, o_Bout = 0 and o_Ovf = 0.
REQ-032 On reset during BUSY or DONE, SHALL discard the operation in flight, with no partial result visible afterward.

Configuration
REQ-033 With macro SUB_SIGNED_OVF_EN defined, SHALL compute o_Ovf per REQ-024.
REQ-034 Without SUB_SIGNED_OVF_EN, SHALL tie o_Ovf to 0 and omit its logic; all other behaviour is unchanged.

Structure
REQ-035 SHALL take the state typedef (IDLE/BUSY/DONE) and the default CHUNK constant from a shared package sub_pkg.
REQ-036 SHALL take the ceil-division function used for NUM_CHUNK from sub_pkg.
REQ-037 SHALL contain one sub-module, sub_chunk: a combinational, WIDTH-parameterised chunk subtractor with ports i_A, i_B, i_Bin, o_Diff, o_Bout, instantiated once at width CHUNK.
REQ-038 SHALL handle the last partial chunk by zero-masking the unused bits of that chunk.

Verification
REQ-039 SHALL cover, with WIDTH=16 and CHUNK=4: A=0x1234, B=0x0234, Bin=0 -> o_Valid 4 cycles after acceptance, Diff=0x1000, Bout=0, Ovf=0.
REQ-040 SHALL cover: A=0x0000, B=0x0001, Bin=0 -> Diff=0xFFFF, Bout=1, Ovf=0.
REQ-041 SHALL cover: A=0x8000, B=0x0001, Bin=0 -> Diff=0x7FFF, Bout=0, Ovf=1 with the macro defined, Ovf=0 without it.
REQ-042 SHALL cover, with WIDTH=10 and CHUNK=4: A=0x005, B=0x005, Bin=1 -> o_Valid after 3 cycles, Diff=0x3FF, Bout=1.
REQ-043 SHALL cover: i_Ready held 0 for 5 cycles in DONE -> outputs stable and o_Ready=0 throughout; consumption on the 6th cycle, then o_Ready=1 on the next cycle.
REQ-044 SHALL cover: reset asserted in the 2nd BUSY cycle -> o_Ready=1, o_Valid=0, o_Diff=0 immediately; the next operation computes correctly.
